jogador_automatico: RTL and testbench

//   Hardware "player" that drives the memory-game circuit's iniciar/chaves inputs with a fixed

---
 rtl/jogador_automatico.sv | 172 +++++++++++++++++
 tb/tb_jogador_automatico.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: drives iniciar/chaves with a fixed play
// sequence (optionally one wrong jogada) and judges the game's pronto/acertou/errou answer.
module jogador_automatico #(
  parameter int unsigned N_JOGADAS = 16,
  parameter int unsigned T_INIC    = 5,
  parameter int unsigned T_PRESS   = 10,
  parameter int unsigned T_GAP     = 10,
  parameter int unsigned ERRO_EM   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar_auto,
  input  logic       pronto,
  input  logic       acertou,
  input  logic       errou,
  output logic       iniciar,
  output logic [3:0] chaves,
  output logic [4:0] jogada_idx,
  output logic       ativo,
  output logic       concluido,
  output logic       resultado_ok
);

  typedef enum logic [2:0] {
    OCIOSO,
    INICIA,
    ESPERA,
    PRESSIONA,
    SOLTA,
    FIM
  } state_t;

  localparam logic [7:0] TIM_INIC  = 8'(T_INIC);
  localparam logic [7:0] TIM_PRESS = 8'(T_PRESS);
  localparam logic [7:0] TIM_GAP   = 8'(T_GAP);
  localparam logic [4:0] ULTIMA    = 5'(N_JOGADAS);

  // An error index beyond the sequence is never reached: play stays correct,
  // but the expectation is still "errou", so such a run can never be judged ok.
  localparam bit         INJETA          = (ERRO_EM != 0);
  localparam bit         ERRO_ALCANCAVEL = (ERRO_EM >= 1) && (ERRO_EM <= N_JOGADAS);
  localparam logic [4:0] ERRO_IDX        = ERRO_ALCANCAVEL ? 5'(ERRO_EM) : 5'd0;

  state_t     state;
  logic [7:0] timer;
  logic       erro_aqui;
  logic       veredito;

  function automatic logic [3:0] rom_valor(input logic [4:0] idx);
    logic [3:0] v;
    case (idx)
      5'd1:    v = 4'b0001;
      5'd2:    v = 4'b0010;
      5'd3:    v = 4'b0100;
      5'd4:    v = 4'b1000;
      5'd5:    v = 4'b0100;
      5'd6:    v = 4'b0010;
      5'd7:    v = 4'b0001;
      5'd8:    v = 4'b0001;
      5'd9:    v = 4'b0010;
      5'd10:   v = 4'b0010;
      5'd11:   v = 4'b0100;
      5'd12:   v = 4'b0100;
      5'd13:   v = 4'b1000;
      5'd14:   v = 4'b1000;
      5'd15:   v = 4'b0001;
      5'd16:   v = 4'b0100;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  // The wrong play is the correct key rotated left by one position.
  function automatic logic [3:0] jogada_valor(input logic [4:0] idx);
    logic [3:0] v;
    v = rom_valor(idx);
    if (ERRO_ALCANCAVEL && (idx == ERRO_IDX)) v = {v[2:0], v[3]};
    return v;
  endfunction

  assign erro_aqui = ERRO_ALCANCAVEL && (jogada_idx == ERRO_IDX);
  assign veredito  = INJETA ? (errou & ~acertou & erro_aqui) : (acertou & ~errou);

  // NOTE: every state and output register is assigned with <= so all of them
  // update together from the values sampled at the same clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= OCIOSO;
      timer        <= 8'd0;
      iniciar      <= 1'b0;
      chaves       <= 4'b0000;
      jogada_idx   <= 5'd0;
      ativo        <= 1'b0;
      concluido    <= 1'b0;
      resultado_ok <= 1'b0;
    end else begin
      case (state)
        OCIOSO, FIM: begin
          if (iniciar_auto) begin
            state        <= INICIA;
            timer        <= TIM_INIC;
            iniciar      <= 1'b1;
            ativo        <= 1'b1;
            chaves       <= 4'b0000;
            jogada_idx   <= 5'd0;
            concluido    <= 1'b0;
            resultado_ok <= 1'b0;
          end
        end

        INICIA, ESPERA, PRESSIONA, SOLTA: begin
          if (pronto) begin
            // The game answered: stop playing at once and latch the verdict.
            state        <= FIM;
            iniciar      <= 1'b0;
            chaves       <= 4'b0000;
            ativo        <= 1'b0;
            concluido    <= 1'b1;
            resultado_ok <= veredito;
          end else if (timer != 8'd1) begin
            timer <= timer - 8'd1;
          end else begin
            case (state)
              INICIA: begin
                state   <= ESPERA;
                timer   <= TIM_GAP;
                iniciar <= 1'b0;
              end
              ESPERA: begin
                state      <= PRESSIONA;
                timer      <= TIM_PRESS;
                jogada_idx <= 5'd1;
                chaves     <= jogada_valor(5'd1);
              end
              PRESSIONA: begin
                state  <= SOLTA;
                timer  <= TIM_GAP;
                chaves <= 4'b0000;
              end
              default: begin
                if (jogada_idx < ULTIMA) begin
                  state      <= PRESSIONA;
                  timer      <= TIM_PRESS;
                  jogada_idx <= jogada_idx + 5'd1;
                  chaves     <= jogada_valor(jogada_idx + 5'd1);
                end else begin
                  // Sequence exhausted and the game never answered: it hung.
                  state        <= FIM;
                  ativo        <= 1'b0;
                  concluido    <= 1'b1;
                  resultado_ok <= 1'b0;
                end
              end
            endcase
          end
        end

        default: begin
          state        <= OCIOSO;
          timer        <= 8'd0;
          iniciar      <= 1'b0;
          chaves       <= 4'b0000;
          jogada_idx   <= 5'd0;
          ativo        <= 1'b0;
          concluido    <= 1'b0;
          resultado_ok <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: one instance plays correctly, a second
// one injects an error at jogada 5; a table holds the expected keys per jogada.
module tb_jogador_automatico;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic       ia0 = 1'b0, pronto0 = 1'b0, acertou0 = 1'b0, errou0 = 1'b0;
  logic       iniciar0, ativo0, conc0, ok0;
  logic [3:0] chaves0;
  logic [4:0] idx0;

  logic       ia1 = 1'b0, pronto1 = 1'b0, acertou1 = 1'b0, errou1 = 1'b0;
  logic       iniciar1, ativo1, conc1, ok1;
  logic [3:0] chaves1;
  logic [4:0] idx1;

  always #5 clock = ~clock;

  jogador_automatico #(.ERRO_EM(0)) dut (
    .clock(clock), .reset(reset), .iniciar_auto(ia0),
    .pronto(pronto0), .acertou(acertou0), .errou(errou0),
    .iniciar(iniciar0), .chaves(chaves0), .jogada_idx(idx0),
    .ativo(ativo0), .concluido(conc0), .resultado_ok(ok0)
  );

  jogador_automatico #(.ERRO_EM(5)) dut_e (
    .clock(clock), .reset(reset), .iniciar_auto(ia1),
    .pronto(pronto1), .acertou(acertou1), .errou(errou1),
    .iniciar(iniciar1), .chaves(chaves1), .jogada_idx(idx1),
    .ativo(ativo1), .concluido(conc1), .resultado_ok(ok1)
  );

  typedef struct {
    int unsigned jogada;
    logic [3:0]  chaves_ok;
    logic [3:0]  chaves_e5;
  } vec_t;

  vec_t tab [1:16];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample(input bit sel, output logic [3:0] ch, output logic ini,
                        output logic at, output logic co, output logic ok,
                        output logic [4:0] idx);
    if (sel) begin
      ch = chaves1; ini = iniciar1; at = ativo1; co = conc1; ok = ok1; idx = idx1;
    end else begin
      ch = chaves0; ini = iniciar0; at = ativo0; co = conc0; ok = ok0; idx = idx0;
    end
  endtask

  task automatic set_ia(input bit sel, input logic v);
    if (sel) ia1 = v;
    else     ia0 = v;
  endtask

  task automatic set_game(input bit sel, input logic p, input logic a, input logic e);
    if (sel) begin pronto1 = p; acertou1 = a; errou1 = e; end
    else     begin pronto0 = p; acertou0 = a; errou0 = e; end
  endtask

  function automatic logic [3:0] chaves_exp(input bit sel, input int j);
    return sel ? tab[j].chaves_e5 : tab[j].chaves_ok;
  endfunction

  // One active phase: len consecutive cycles with identical expected outputs.
  task automatic phase(input bit sel, input string name, input logic [3:0] ch,
                       input logic ini, input logic [4:0] idx, input int len);
    logic [3:0] c;
    logic       i, a, co, ok;
    logic [4:0] x;
    int         bad;
    bad = 0;
    for (int n = 0; n < len; n++) begin
      sample(sel, c, i, a, co, ok, x);
      if ({c, i, a, co, x} !== {ch, ini, 1'b1, 1'b0, idx}) bad++;
      tick();
    end
    check(name, bad, 0);
  endtask

  task automatic start(input bit sel, input bit hold);
    set_ia(sel, 1'b1);
    tick();
    if (!hold) set_ia(sel, 1'b0);
  endtask

  // INICIA, ESPERA, `full` complete jogadas, then press_len cycles of the next press.
  task automatic jogadas(input bit sel, input int full, input int press_len);
    phase(sel, $sformatf("dut%0d inicia", sel), 4'b0000, 1'b1, 5'd0, 5);
    phase(sel, $sformatf("dut%0d espera", sel), 4'b0000, 1'b0, 5'd0, 10);
    for (int j = 1; j <= full; j++) begin
      phase(sel, $sformatf("dut%0d jogada %0d press", sel, j), chaves_exp(sel, j), 1'b0, 5'(j), 10);
      phase(sel, $sformatf("dut%0d jogada %0d solta", sel, j), 4'b0000, 1'b0, 5'(j), 10);
    end
    if (press_len > 0)
      phase(sel, $sformatf("dut%0d jogada %0d press", sel, full + 1),
            chaves_exp(sel, full + 1), 1'b0, 5'(full + 1), press_len);
  endtask

  task automatic check_fim(input bit sel, input string name, input logic ok_exp,
                           input logic [4:0] idx_exp);
    logic [3:0] c;
    logic       i, a, co, ok;
    logic [4:0] x;
    sample(sel, c, i, a, co, ok, x);
    check({name, " concluido"}, co, 1'b1);
    check({name, " resultado_ok"}, ok, ok_exp);
    check({name, " jogada_idx"}, x, idx_exp);
    check({name, " chaves/iniciar/ativo"}, {c, i, a}, 6'b0);
  endtask

  initial begin
    logic [3:0] c;
    logic       i, a, co, ok;
    logic [4:0] x;
    int         bad;

    tab[1]  = '{1,  4'b0001, 4'b0001};
    tab[2]  = '{2,  4'b0010, 4'b0010};
    tab[3]  = '{3,  4'b0100, 4'b0100};
    tab[4]  = '{4,  4'b1000, 4'b1000};
    tab[5]  = '{5,  4'b0100, 4'b1000};
    tab[6]  = '{6,  4'b0010, 4'b0010};
    tab[7]  = '{7,  4'b0001, 4'b0001};
    tab[8]  = '{8,  4'b0001, 4'b0001};
    tab[9]  = '{9,  4'b0010, 4'b0010};
    tab[10] = '{10, 4'b0010, 4'b0010};
    tab[11] = '{11, 4'b0100, 4'b0100};
    tab[12] = '{12, 4'b0100, 4'b0100};
    tab[13] = '{13, 4'b1000, 4'b1000};
    tab[14] = '{14, 4'b1000, 4'b1000};
    tab[15] = '{15, 4'b0001, 4'b0001};
    tab[16] = '{16, 4'b0100, 4'b0100};

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("reset dut0 outputs", {iniciar0, chaves0, idx0, ativo0, conc0, ok0}, 13'd0);
    check("reset dut_e outputs", {iniciar1, chaves1, idx1, ativo1, conc1, ok1}, 13'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Full correct run, game answers acertou during the 16th release
    start(0, 0);
    jogadas(0, 15, 10);
    phase(0, "dut0 jogada 16 solta", 4'b0000, 1'b0, 5'd16, 5);
    set_game(0, 1'b1, 1'b1, 1'b0);
    tick();
    check_fim(0, "t2 fim", 1'b1, 5'd16);
    tick(); tick(); tick();
    check_fim(0, "t2 pronto ignored in fim", 1'b1, 5'd16);
    set_game(0, 1'b0, 1'b0, 1'b0);

    // Restart from FIM clears the verdict, then reset in the middle of a press
    start(0, 0);
    sample(0, c, i, a, co, ok, x);
    check("t6 restart concluido/ok/idx", {co, ok, x}, 7'd0);
    check("t6 restart iniciar", i, 1'b1);
    jogadas(0, 0, 3);
    reset = 1'b0;
    #1;
    check("t1 async reset chaves", chaves0, 4'b0000);
    check("t1 async reset ativo/iniciar/idx", {ativo0, iniciar0, idx0}, 7'd0);
    tick();
    reset = 1'b1;
    set_game(0, 1'b1, 1'b1, 1'b0);
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if ({iniciar0, chaves0, idx0, ativo0, conc0, ok0} !== 13'd0) bad++;
    end
    check("t1 stays ocioso, pronto ignored", bad, 0);
    set_game(0, 1'b0, 1'b0, 1'b0);

    // Correct play but the game says errou at jogada 3
    start(0, 0);
    jogadas(0, 2, 4);
    set_game(0, 1'b1, 1'b0, 1'b1);
    tick();
    set_game(0, 1'b0, 1'b0, 1'b0);
    check_fim(0, "t4 fim", 1'b0, 5'd3);

    // Error injected at jogada 5, game answers errou during that press
    start(1, 0);
    jogadas(1, 4, 6);
    set_game(1, 1'b1, 1'b0, 1'b1);
    tick();
    set_game(1, 1'b0, 1'b0, 1'b0);
    check_fim(1, "t3 fim", 1'b1, 5'd5);

    // Game never answers; iniciar_auto held high throughout the run
    start(0, 1);
    jogadas(0, 16, 0);
    check_fim(0, "t5 fim", 1'b0, 5'd16);
    tick();
    sample(0, c, i, a, co, ok, x);
    check("t5 held iniciar_auto restarts from fim", {i, a, co}, 3'b110);
    set_ia(0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
